// File: rtl/cam_learn_ctrl.sv
// cam_learn_ctrl: lookup/learn sequencer in front of a DEPTHxKEY_W exact-match CAM.
// Optional build macro: CAM_LEARN_STATS_EN (adds stat_hits/stat_misses/stat_evicts).
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op, req_key     0 = lookup, 1 = learn; key to search/insert
//   rsp_valid/ready     response handshake
//   rsp_hit/addr/new/evict  result of the transaction
//   cam_we/waddr/data/search  CAM control pins
//   cam_saddr, cam_found      CAM priority-match address / any-match
//   stat_*              (CAM_LEARN_STATS_EN) saturating 16-bit counters
module cam_learn_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int KEY_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_new,
  output logic              rsp_evict,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [KEY_W-1:0]  cam_data,
  output logic              cam_search,
  input  logic [ADDR_W-1:0] cam_saddr,
  input  logic              cam_found
`ifdef CAM_LEARN_STATS_EN
  ,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_misses,
  output logic [15:0]       stat_evicts
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t              state_q;
  logic [ADDR_W:0]     fill_cnt_q;
  logic [ADDR_W-1:0]   rr_ptr_q;
  logic [KEY_W-1:0]    key_q;
  logic                op_q;
  logic                found_q;
  logic [ADDR_W-1:0]   saddr_q;
  logic [ADDR_W-1:0]   vaddr_q;
  logic                hit_q;
  logic                new_q;
  logic                evict_q;
  logic                valid_q;
  logic                ready_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [KEY_W-1:0]    data_q;
  logic                search_q;

  logic                full;
  logic [ADDR_W-1:0]   victim;
  logic                hit;

  assign full   = (fill_cnt_q == FULL_CNT);
  assign victim = full ? rr_ptr_q : fill_cnt_q[ADDR_W-1:0];

  // Unwritten slots hold zero, so a match there is not a real hit.
  assign hit = found_q &&
               (full || ({1'b0, cam_saddr} < fill_cnt_q));

  assign req_ready  = ready_q;
  assign rsp_valid  = valid_q;
  assign rsp_hit    = hit_q;
  // Hit reports the captured match address; otherwise the victim (0 on lookup miss).
  assign rsp_addr   = hit_q ? saddr_q : vaddr_q;
  assign rsp_new    = new_q;
  assign rsp_evict  = evict_q;
  assign cam_we     = we_q;
  assign cam_waddr  = waddr_q;
  assign cam_data   = data_q;
  assign cam_search = search_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      rr_ptr_q   <= '0;
      key_q      <= '0;
      op_q       <= 1'b0;
      found_q    <= 1'b0;
      saddr_q    <= '0;
      vaddr_q    <= '0;
      hit_q      <= 1'b0;
      new_q      <= 1'b0;
      evict_q    <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
      search_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            key_q    <= req_key;
            op_q     <= req_op;
            ready_q  <= 1'b0;
            data_q   <= req_key;
            search_q <= 1'b1;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          found_q <= cam_found;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          saddr_q  <= cam_saddr;
          search_q <= 1'b0;
          if (hit) begin
            hit_q   <= 1'b1;
            vaddr_q <= '0;
            valid_q <= 1'b1;
            data_q  <= '0;
            state_q <= RESP;
          end else if (!op_q) begin
            vaddr_q <= '0;
            valid_q <= 1'b1;
            data_q  <= '0;
            state_q <= RESP;
          end else begin
            // data_q still holds key_q for the write cycle
            we_q    <= 1'b1;
            waddr_q <= victim;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          waddr_q <= '0;
          data_q  <= '0;
          if (full) begin
            rr_ptr_q <= rr_ptr_q + 1'b1;
            evict_q  <= 1'b1;
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
          new_q   <= 1'b1;
          vaddr_q <= victim;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            hit_q   <= 1'b0;
            new_q   <= 1'b0;
            evict_q <= 1'b0;
            vaddr_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CAM_LEARN_STATS_EN
  logic [15:0] hits_q;
  logic [15:0] misses_q;
  logic [15:0] evicts_q;

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_evicts = evicts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      evicts_q <= '0;
    end else if (valid_q && rsp_ready) begin
      if (hit_q && hits_q != 16'hFFFF)
        hits_q <= hits_q + 16'd1;
      if (!hit_q && misses_q != 16'hFFFF)
        misses_q <= misses_q + 16'd1;
      if (evict_q && evicts_q != 16'hFFFF)
        evicts_q <= evicts_q + 16'd1;
    end
  end
`endif

endmodule
